// File: rtl/mspi_pkg.sv
// mspi_pkg: shared FSM state encoding, transfer-length codes and bit-count lookup.
`default_nettype none
package mspi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEAD = 3'd1,
      ST_HIGH = 3'd2,
      ST_LOW  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam logic [1:0] LEN8  = 2'd0;
   localparam logic [1:0] LEN16 = 2'd1;
   localparam logic [1:0] LEN32 = 2'd2;

   // Codes 2 and 3 both select a full 32-bit transfer.
   function automatic logic [5:0] len_bits(input logic [1:0] len);
      logic [5:0] n;
      case (len)
         LEN8:    n = 6'd8;
         LEN16:   n = 6'd16;
         default: n = 6'd32;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mspi_clkgen.sv
// mspi_clkgen: half-period counter; tick_o marks the last clk cycle of each H-cycle phase.
`default_nettype none
module mspi_clkgen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr_i,
   input  logic [DIV_W-1:0] half_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   assign tick_o = !clr_i && (cnt_q == (half_i - DIV_W'(1)));

   always_comb begin
      cnt_d = cnt_q + DIV_W'(1);
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mspi.sv
// mspi: mode-0 SPI master, 8/16/32-bit transfers with programmable SCK half-period.
// Build option: define MSPI_LOOPBACK_EN to receive from sdo instead of the sdi pin.
`default_nettype none
module mspi
   import mspi_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [DIV_W-1:0] clk_div,
   input  logic             wr,
   input  logic [1:0]       wr_len,
   input  logic [31:0]      wrdata,
   output logic [31:0]      rddata,
   output logic             wr_done,
   output logic             sck,
   input  logic             sdi,
   output logic             sdo,
   output logic             ss,
   output logic             ready
);

   state_e           state_q, state_d;
   logic [31:0]      tx_q, tx_d;
   logic [31:0]      rx_q, rx_d;
   logic [31:0]      rd_q, rd_d;
   logic [DIV_W-1:0] h_q, h_d;
   logic [5:0]       n_q, n_d;
   logic [5:0]       bit_q, bit_d;
   logic             w_tick;
   logic             w_clr;
   logic             w_rx_in;

`ifdef MSPI_LOOPBACK_EN
   assign w_rx_in = sdo;
`else
   assign w_rx_in = sdi;
`endif

   assign w_clr   = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign ss      = !((state_q == ST_LEAD) || (state_q == ST_HIGH) || (state_q == ST_LOW));
   assign sck     = (state_q == ST_HIGH);
   assign ready   = w_clr;
   assign wr_done = (state_q == ST_DONE);
   assign sdo     = ss ? 1'b0 : tx_q[31];
   assign rddata  = rd_q;

   mspi_clkgen #(
      .DIV_W (DIV_W)
   ) u_clkgen (
      .clk    (clk),
      .rstn   (rstn),
      .clr_i  (w_clr),
      .half_i (h_q),
      .tick_o (w_tick)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rd_d    = rd_q;
      h_d     = h_q;
      n_d     = n_q;
      bit_d   = bit_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (wr) begin
               state_d = ST_LEAD;
               tx_d    = wrdata;
               rx_d    = '0;
               n_d     = len_bits(wr_len);
               h_d     = (clk_div == '0) ? DIV_W'(1) : clk_div;
               bit_d   = '0;
            end
         end
         ST_LEAD: begin
            if (w_tick) begin
               state_d = ST_HIGH;
               rx_d    = {rx_q[30:0], w_rx_in};
            end
         end
         ST_HIGH: begin
            if (w_tick) begin
               state_d = ST_LOW;
               tx_d    = {tx_q[30:0], 1'b0};
               bit_d   = bit_q + 6'd1;
            end
         end
         ST_LOW: begin
            // The LOW phase after the last bit is the trailing half-period.
            if (w_tick) begin
               if (bit_q == n_q) begin
                  state_d = ST_DONE;
                  rd_d    = rx_q;
               end else begin
                  state_d = ST_HIGH;
                  rx_d    = {rx_q[30:0], w_rx_in};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         rd_q    <= '0;
         h_q     <= '0;
         n_q     <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rd_q    <= rd_d;
         h_q     <= h_d;
         n_q     <= n_d;
         bit_q   <= bit_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mspi.sv
// tb_mspi: directed self-checking bench for the mspi SPI master.
`default_nettype none
module tb_mspi;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  clk_div = 8'd1;
   logic        wr = 1'b0;
   logic [1:0]  wr_len = 2'd0;
   logic [31:0] wrdata = 32'h0;
   logic [31:0] rddata;
   logic        wr_done;
   logic        sck;
   logic        sdi;
   logic        sdo;
   logic        ss;
   logic        ready;

   int checks = 0;
   int errors = 0;

   // slave model and monitors
   logic        loop_en = 1'b0;
   logic [31:0] slave_val = 32'h0;
   logic [31:0] slave_sh = 32'h0;
   int          ss_cnt = 0;
   int          sck_edges = 0;
   int          done_cnt = 0;
   int          bad_ready = 0;
   logic [31:0] mosi = 32'h0;
   logic        sck_prev = 1'b0;

   assign sdi = loop_en ? sdo : slave_sh[31];

   always #5 clk = ~clk;

   mspi #(.DIV_W(8)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .clk_div (clk_div),
      .wr      (wr),
      .wr_len  (wr_len),
      .wrdata  (wrdata),
      .rddata  (rddata),
      .wr_done (wr_done),
      .sck     (sck),
      .sdi     (sdi),
      .sdo     (sdo),
      .ss      (ss),
      .ready   (ready)
   );

   always @(negedge ss)  slave_sh = slave_val;
   always @(negedge sck) slave_sh = {slave_sh[30:0], 1'b0};

   always @(negedge clk) begin
      if (rstn) begin
         if (!ss) ss_cnt++;
         if (!ss && ready) bad_ready++;
         if (sck && !sck_prev) begin
            sck_edges++;
            mosi = {mosi[30:0], sdo};
         end
         if (wr_done) done_cnt++;
      end
      sck_prev = sck;
   end

   task automatic clr_mon();
      @(posedge clk);
      ss_cnt = 0; sck_edges = 0; done_cnt = 0; bad_ready = 0; mosi = 32'h0;
   endtask

   task automatic start(input logic [7:0] div, input logic [1:0] len, input logic [31:0] data);
      clr_mon();
      @(negedge clk);
      clk_div = div; wr_len = len; wrdata = data; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (wr_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if ({ss, sck, sdo, wr_done, ready} !== 5'b10001) begin
         errors++; $display("FAIL reset_outputs: got ss/sck/sdo/done/ready=%b want 10001", {ss, sck, sdo, wr_done, ready});
      end
      checks++;
      if (rddata !== 32'h0) begin
         errors++; $display("FAIL reset_rddata: got %h want 00000000", rddata);
      end
   endtask

   task automatic test_basic8();
      bit ok;
      loop_en = 1'b0; slave_val = 32'h3C000000;
      start(8'd4, 2'd0, 32'hA5000000);
      checks++;
      if (ready !== 1'b0 || ss !== 1'b0) begin
         errors++; $display("FAIL basic_busy: got ready=%b ss=%b want 0 0", ready, ss);
      end
      wait_done(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL basic_timeout: got no wr_done want wr_done");
      end
      checks++;
      if (rddata !== 32'h0000003C) begin
         errors++; $display("FAIL basic_rddata: got %h want 0000003c", rddata);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (mosi[7:0] !== 8'hA5) begin
         errors++; $display("FAIL basic_mosi: got %h want a5", mosi[7:0]);
      end
      checks++;
      if (sck_edges != 8) begin
         errors++; $display("FAIL basic_edges: got %0d want 8", sck_edges);
      end
      checks++;
      if (ss_cnt != 68) begin
         errors++; $display("FAIL basic_ss_len: got %0d want 68", ss_cnt);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt);
      end
   endtask

   task automatic test_loop16();
      bit ok;
      loop_en = 1'b1;
      start(8'd1, 2'd1, 32'h12340000);
      wait_done(ok);
      checks++;
      if (!ok || rddata !== 32'h00001234) begin
         errors++; $display("FAIL loop16_rddata: got %h ok=%0d want 00001234", rddata, ok);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (ss_cnt != 33) begin
         errors++; $display("FAIL loop16_ss_len: got %0d want 33", ss_cnt);
      end
   endtask

   task automatic test_loop32();
      bit ok;
      loop_en = 1'b1;
      start(8'd2, 2'd2, 32'hDEADBEEF);
      wait_done(ok);
      checks++;
      if (!ok || rddata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL loop32_rddata: got %h ok=%0d want deadbeef", rddata, ok);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (sck_edges != 32 || ss_cnt != 130) begin
         errors++; $display("FAIL loop32_timing: got edges=%0d ss=%0d want 32 130", sck_edges, ss_cnt);
      end
      start(8'd1, 2'd3, 32'h0F0F1234);
      wait_done(ok);
      checks++;
      if (!ok || rddata !== 32'h0F0F1234) begin
         errors++; $display("FAIL len3_rddata: got %h ok=%0d want 0f0f1234", rddata, ok);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (ss_cnt != 65) begin
         errors++; $display("FAIL len3_ss_len: got %0d want 65", ss_cnt);
      end
   endtask

   task automatic test_wr_ignored();
      bit ok;
      loop_en = 1'b0; slave_val = 32'h96000000;
      start(8'd2, 2'd0, 32'h81000000);
      repeat (10) @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin
         errors++; $display("FAIL ignored_ready: got %b want 0", ready);
      end
      wr = 1'b1; clk_div = 8'd7; wr_len = 2'd2; wrdata = 32'hFFFFFFFF;
      @(negedge clk);
      wr = 1'b0;
      wait_done(ok);
      checks++;
      if (!ok || rddata !== 32'h00000096) begin
         errors++; $display("FAIL ignored_rddata: got %h ok=%0d want 00000096", rddata, ok);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (mosi[7:0] !== 8'h81 || ss_cnt != 34) begin
         errors++; $display("FAIL ignored_xfer: got mosi=%h ss=%0d want 81 34", mosi[7:0], ss_cnt);
      end
      checks++;
      if (done_cnt != 1 || bad_ready != 0) begin
         errors++; $display("FAIL ignored_done: got done=%0d ready_busy=%0d want 1 0", done_cnt, bad_ready);
      end
   endtask

   task automatic test_abort();
      bit ok;
      loop_en = 1'b1;
      start(8'd4, 2'd0, 32'h5A000000);
      for (int i = 0; i < 500 && sck_edges < 3; i++) @(negedge clk);
      checks++;
      if (sck_edges != 3) begin
         errors++; $display("FAIL abort_reach_bit3: got edges=%0d want 3", sck_edges);
      end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++;
      if ({ss, sck, sdo, ready, wr_done} !== 5'b10010) begin
         errors++; $display("FAIL abort_outputs: got ss/sck/sdo/ready/done=%b want 10010", {ss, sck, sdo, ready, wr_done});
      end
      checks++;
      if (rddata !== 32'h0) begin
         errors++; $display("FAIL abort_rddata: got %h want 00000000", rddata);
      end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (done_cnt != 0) begin
         errors++; $display("FAIL abort_no_done: got %0d want 0", done_cnt);
      end
      start(8'd1, 2'd0, 32'h5A000000);
      wait_done(ok);
      checks++;
      if (!ok || rddata !== 32'h0000005A) begin
         errors++; $display("FAIL abort_recover: got %h ok=%0d want 0000005a", rddata, ok);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (ss_cnt != 17) begin
         errors++; $display("FAIL abort_recover_ss: got %0d want 17", ss_cnt);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      loop_en = 1'b1;
      start(8'd0, 2'd0, 32'hC3000000);
      wait_done(ok);
      checks++;
      if (!ok || rddata !== 32'h000000C3) begin
         errors++; $display("FAIL b2b_first: got %h ok=%0d want 000000c3", rddata, ok);
      end
      wrdata = 32'h3C000000; wr_len = 2'd0; clk_div = 8'd0; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      checks++;
      if (ss !== 1'b0 || ready !== 1'b0) begin
         errors++; $display("FAIL b2b_no_gap: got ss=%b ready=%b want 0 0", ss, ready);
      end
      wait_done(ok);
      checks++;
      if (!ok || rddata !== 32'h0000003C) begin
         errors++; $display("FAIL b2b_second: got %h ok=%0d want 0000003c", rddata, ok);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (ss_cnt != 34 || done_cnt != 2) begin
         errors++; $display("FAIL b2b_counts: got ss=%0d done=%0d want 34 2", ss_cnt, done_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic8();
      test_loop16();
      test_loop32();
      test_wr_ignored();
      test_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mspi.md
MSPI -- requirements
Module: mspi

Interface
REQ-001 Parameter DIV_W, default 8, width of clk_div.
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 clk_div  in  DIV_W  SCK half-period in clk cycles (H = clk_div; 0 treated as 1); sampled on wr.
REQ-005 wr  in  1  start-transfer strobe; accepted only while ready=1.
REQ-006 wr_len  in  2  transfer length: 0=8 bits, 1=16 bits, 2 or 3=32 bits; sampled on wr.
REQ-007 wrdata  in  32  transmit data, left-justified: first bit sent is wrdata[31].
REQ-008 rddata  out  32  receive data, right-justified: last bit received lands in rddata[0].
REQ-009 wr_done  out  1  one-cycle pulse at transfer end.
REQ-010 sck  out  1  SPI clock, mode 0 (idle low).
REQ-011 sdi  in  1  MISO.
REQ-012 sdo  out  1  MOSI.
REQ-013 ss  out  1  slave select, active-low.
REQ-014 ready  out  1  high when idle and able to accept wr.

Function
REQ-015 States: IDLE, LEAD, HIGH, LOW, DONE.
REQ-016 IDLE: ready=1, ss=1, sck=0. wr=1 latches wrdata, wr_len and H, clears the bit counter, and enters LEAD on the next cycle.
REQ-017 LEAD: ss=0, sck=0, ready=0, sdo=wrdata[31]; lasts H cycles, then HIGH.
REQ-018 HIGH: sck=1 for H cycles; sdi is sampled on entry (the rising SCK edge) and shifted into the receive register LSB.
REQ-019 LOW: sck=0 for H cycles; on entry sdo advances to the next TX bit; after the Nth bit, LOW is the trailing phase and exits to DONE, otherwise to HIGH.
REQ-020 N = 8, 16 or 32 per wr_len; ss is low for exactly H + 2*N*H cycles.
REQ-021 DONE (one cycle): ss=1, wr_done=1, ready=1, and rddata is updated with the received bits zero-extended to 32 bits; the next state is IDLE.
REQ-022 rddata holds its value until the next DONE.
REQ-023 wr while ready=0 is ignored; wr in the DONE cycle is accepted.
REQ-024 Changes to clk_div, wr_len or wrdata during a transfer have no effect.
REQ-025 sdo=0 whenever ss=1.

Reset
REQ-026 rstn low asynchronously forces IDLE: ss=1, sck=0, sdo=0, wr_done=0, ready=1, rddata=0, counters cleared.
REQ-027 Reset mid-transfer aborts it with no wr_done pulse; the first wr after release starts a clean transfer.

Configuration
REQ-028 Macro MSPI_LOOPBACK_EN: when defined, the internal receive input is sdo and the sdi pin is ignored, so rddata equals the transmitted bits; when undefined, sdi is used.

Structure
REQ-029 A shared package mspi_pkg holds the state enum, the wr_len encodings (LEN8=0, LEN16=1, LEN32=2) and the bit-count lookup.
REQ-030 One sub-module, mspi_clkgen, provides the H-cycle half-period counter and its tick; the shift registers and FSM stay in mspi.

Verification
REQ-031 clk_div=4, wr_len=0, wrdata=32'hA5000000, slave returns 8'h3C -> sdo carries A5 MSB-first, 8 rising SCK edges, ss low 68 cycles, a single wr_done pulse, rddata=32'h0000003C.
REQ-032 clk_div=1, wr_len=1, wrdata=32'h12340000, sdi looped to sdo -> rddata=32'h00001234, ss low 33 cycles.
REQ-033 wr_len=2, clk_div=2, wrdata=32'hDEADBEEF, MSPI_LOOPBACK_EN defined -> rddata=32'hDEADBEEF, 32 SCK pulses.
REQ-034 wr pulsed mid-transfer -> ignored; exactly one wr_done; ready stays low until DONE.
REQ-035 rstn asserted during bit 3 -> ss=1, sck=0, ready=1 immediately, no wr_done; a following 8-bit transfer completes correctly.
REQ-036 clk_div=0 -> behaves as clk_div=1; back-to-back wr on the DONE cycle starts the next transfer without an idle gap.
